// File: rtl/score_pkg.sv
// Shared types and default tuning constants for the note-highway hit judge.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    JUDGED = 2'd2
  } lane_state_t;

  localparam int unsigned NUM_LANES_DEF  = 5;
  localparam int unsigned POS_W_DEF      = 10;
  localparam int unsigned SCORE_W_DEF    = 16;
  localparam int unsigned COMBO_W_DEF    = 8;
  localparam int unsigned HIT_LO_DEF     = 410;
  localparam int unsigned HIT_HI_DEF     = 440;
  localparam int unsigned PERF_LO_DEF    = 420;
  localparam int unsigned PERF_HI_DEF    = 430;
  localparam int unsigned COMBO_STEP_DEF = 8;
  localparam int unsigned MAX_MULT_DEF   = 4;
  localparam int unsigned MULT_W         = 3;

endpackage

// File: rtl/lane_judge.sv
// One lane of the hit judge: key edge detect, IDLE/ARMED/JUDGED FSM and
// registered hit/perfect/miss pulses.
// Optional macro GHOST_PENALTY_EN: a key edge outside ARMED registers a miss.
module lane_judge
  import score_pkg::*;
#(
  parameter int unsigned POS_W   = POS_W_DEF,
  parameter int unsigned HIT_LO  = HIT_LO_DEF,
  parameter int unsigned HIT_HI  = HIT_HI_DEF,
  parameter int unsigned PERF_LO = PERF_LO_DEF,
  parameter int unsigned PERF_HI = PERF_HI_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] y_pos,
  input  logic             key,
  output logic             hit_pulse,
  output logic             perfect_pulse,
  output logic             miss_pulse
);

  localparam logic [POS_W-1:0] HIT_LO_Y  = POS_W'(HIT_LO);
  localparam logic [POS_W-1:0] HIT_HI_Y  = POS_W'(HIT_HI);
  localparam logic [POS_W-1:0] PERF_LO_Y = POS_W'(PERF_LO);
  localparam logic [POS_W-1:0] PERF_HI_Y = POS_W'(PERF_HI);

  lane_state_t state_q, state_d;
  logic        key_q, key_d;
  logic        hit_q, hit_d;
  logic        perf_q, perf_d;
  logic        miss_q, miss_d;
  logic        key_edge;
  logic        in_win;
  logic        in_perf;

  // Next-state and pulse decode for this lane.
  always_comb begin
    key_d    = key;
    key_edge = key & ~key_q;
    in_win   = (y_pos > HIT_LO_Y) && (y_pos < HIT_HI_Y);
    in_perf  = (y_pos > PERF_LO_Y) && (y_pos < PERF_HI_Y);
    state_d  = state_q;
    hit_d    = 1'b0;
    perf_d   = 1'b0;
    miss_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_win) state_d = ARMED;
`ifdef GHOST_PENALTY_EN
        if (key_edge) miss_d = 1'b1;
`endif
      end
      ARMED: begin
        if (key_edge) begin
          state_d = JUDGED;
          hit_d   = 1'b1;
          perf_d  = in_perf;
        end else if (y_pos >= HIT_HI_Y) begin
          state_d = JUDGED;
          miss_d  = 1'b1;
        end else if (y_pos <= HIT_LO_Y) begin
          state_d = IDLE;
        end
      end
      JUDGED: begin
        if (y_pos <= HIT_LO_Y) state_d = IDLE;
`ifdef GHOST_PENALTY_EN
        if (key_edge) miss_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane state, key history and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      hit_q   <= 1'b0;
      perf_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      perf_q  <= perf_d;
      miss_q  <= miss_d;
    end
  end

  assign hit_pulse     = hit_q;
  assign perfect_pulse = perf_q;
  assign miss_pulse    = miss_q;

endmodule

// File: rtl/score_judge.sv
// Multi-lane hit judge with per-player saturating scores and a combo-driven
// multiplier. Optional macro GHOST_PENALTY_EN (handled inside lane_judge).
module score_judge
  import score_pkg::*;
#(
  parameter int unsigned NUM_LANES  = NUM_LANES_DEF,
  parameter int unsigned POS_W      = POS_W_DEF,
  parameter int unsigned SCORE_W    = SCORE_W_DEF,
  parameter int unsigned COMBO_W    = COMBO_W_DEF,
  parameter int unsigned HIT_LO     = HIT_LO_DEF,
  parameter int unsigned HIT_HI     = HIT_HI_DEF,
  parameter int unsigned PERF_LO    = PERF_LO_DEF,
  parameter int unsigned PERF_HI    = PERF_HI_DEF,
  parameter int unsigned COMBO_STEP = COMBO_STEP_DEF,
  parameter int unsigned MAX_MULT   = MAX_MULT_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_LANES*POS_W-1:0] lane_y_pos,
  input  logic [NUM_LANES-1:0]       lane_key,
  input  logic                       player_sel,
  input  logic                       score_clear,
  output logic [SCORE_W-1:0]         score_1,
  output logic [SCORE_W-1:0]         score_2,
  output logic [COMBO_W-1:0]         combo,
  output logic [MULT_W-1:0]          multiplier,
  output logic [NUM_LANES-1:0]       hit_pulse,
  output logic [NUM_LANES-1:0]       perfect_pulse,
  output logic [NUM_LANES-1:0]       miss_pulse
);

  localparam int unsigned BASE_W = $clog2(2 * NUM_LANES + 1);
  localparam int unsigned CNT_W  = $clog2(NUM_LANES + 1);

  logic [BASE_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic               miss_any_q, miss_any_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic [SCORE_W-1:0] add;
  logic [SCORE_W:0]   sum1;
  logic [SCORE_W:0]   sum2;
  logic [COMBO_W:0]   combo_sum;
  logic [COMBO_W-1:0] steps;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_judge #(
      .POS_W  (POS_W),
      .HIT_LO (HIT_LO),
      .HIT_HI (HIT_HI),
      .PERF_LO(PERF_LO),
      .PERF_HI(PERF_HI)
    ) u_lane (
      .clk          (Clk),
      .rst_n        (Reset_n),
      .y_pos        (lane_y_pos[g*POS_W +: POS_W]),
      .key          (lane_key[g]),
      .hit_pulse    (hit_pulse[g]),
      .perfect_pulse(perfect_pulse[g]),
      .miss_pulse   (miss_pulse[g])
    );
  end

  // Reduce this cycle's lane pulses to base points, hit count and miss flag;
  // a clear in the same cycle drops them so they never reach the scores.
  always_comb begin
    base_d     = '0;
    hits_d     = '0;
    miss_any_d = |miss_pulse;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (perfect_pulse[i]) base_d = base_d + BASE_W'(2);
      else if (hit_pulse[i]) base_d = base_d + BASE_W'(1);
      if (hit_pulse[i]) hits_d = hits_d + CNT_W'(1);
    end
    if (score_clear) begin
      base_d     = '0;
      hits_d     = '0;
      miss_any_d = 1'b0;
    end
  end

  // Accumulate scores with the pre-update multiplier, then advance the combo
  // and derive the next multiplier from the new combo value.
  always_comb begin
    add       = SCORE_W'(base_q) * SCORE_W'(mult_q);
    sum1      = {1'b0, score1_q} + {1'b0, add};
    sum2      = {1'b0, score2_q} + {1'b0, add};
    score1_d  = score1_q;
    score2_d  = score2_q;
    if (player_sel) score1_d = sum1[SCORE_W] ? '1 : sum1[SCORE_W-1:0];
    else            score2_d = sum2[SCORE_W] ? '1 : sum2[SCORE_W-1:0];
    combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(hits_q);
    if (miss_any_q) combo_d = '0;
    else            combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    steps = combo_d / COMBO_W'(COMBO_STEP);
    if (steps >= COMBO_W'(MAX_MULT - 1)) mult_d = MULT_W'(MAX_MULT);
    else                                 mult_d = MULT_W'(steps) + MULT_W'(1);
    if (score_clear) begin
      score1_d = '0;
      score2_d = '0;
      combo_d  = '0;
      mult_d   = MULT_W'(1);
    end
  end

  // Pulse summary stage and score/combo/multiplier registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q     <= '0;
      hits_q     <= '0;
      miss_any_q <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
      combo_q    <= '0;
      mult_q     <= MULT_W'(1);
    end else begin
      base_q     <= base_d;
      hits_q     <= hits_d;
      miss_any_q <= miss_any_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      combo_q    <= combo_d;
      mult_q     <= mult_d;
    end
  end

  assign score_1    = score1_q;
  assign score_2    = score2_q;
  assign combo      = combo_q;
  assign multiplier = mult_q;

endmodule

// File: doc/score_judge.md
Name: score_judge

Overview:
Parametrised multi-lane hit judge and score accumulator for the note highway.
- Compares each lane's falling-note Y position against a GOOD window and a nested PERFECT window, using the rising edge of the lane's key.
- Holds per-lane judge state, so each note scores at most once and an unhit note registers as a miss.
- Keeps per-player scores with a combo-driven multiplier, feeding the score display and game-over logic.

Parameters:
NUM_LANES, 5, number of note lanes
POS_W, 10, Y position width
SCORE_W, 16, score register width, saturating
COMBO_W, 8, combo counter width, saturating
HIT_LO, 410, GOOD window lower bound, exclusive
HIT_HI, 440, GOOD window upper bound, exclusive
PERF_LO, 420, PERFECT window lower bound, exclusive; must satisfy HIT_LO <= PERF_LO
PERF_HI, 430, PERFECT window upper bound, exclusive; must satisfy PERF_HI <= HIT_HI
COMBO_STEP, 8, consecutive hits per multiplier step
MAX_MULT, 4, multiplier ceiling

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
lane_y_pos  in  NUM_LANES*POS_W  packed note Y positions, lane 0 in the LSBs
lane_key  in  NUM_LANES  decoded key level per lane, 1 = held
player_sel  in  1  1 = credit player 1, 0 = credit player 2
score_clear  in  1  synchronous clear of scores and combo
score_1  out  SCORE_W  player 1 score
score_2  out  SCORE_W  player 2 score
combo  out  COMBO_W  current consecutive-hit count
multiplier  out  3  current multiplier, range 1..MAX_MULT
hit_pulse  out  NUM_LANES  1-cycle pulse per lane on a GOOD or PERFECT hit
perfect_pulse  out  NUM_LANES  1-cycle pulse per lane on a PERFECT hit
miss_pulse  out  NUM_LANES  1-cycle pulse per lane on a miss

Behaviour:
- Reset: all outputs and state go to 0, except multiplier = 1. Per-lane state resets to IDLE. Key history resets to 0.
- Key edge: key_q is registered per lane. edge = lane_key & ~key_q. A held key never re-triggers.
- Window tests: in_win = HIT_LO < y < HIT_HI. in_perf = PERF_LO < y < PERF_HI.
- Per-lane FSM:
  - IDLE -> ARMED when in_win.
  - ARMED, with edge -> JUDGED. Registered hit_pulse is asserted; perfect_pulse is also asserted if in_perf.
  - ARMED, with y >= HIT_HI -> JUDGED. Registered miss_pulse is asserted.
  - ARMED, with y <= HIT_LO (note respawned) -> IDLE, no pulse.
  - JUDGED -> IDLE when y <= HIT_LO (next note).
  - A lane may enter at y >= HIT_HI without passing through the window. It stays IDLE and produces no miss.
- Latency:
  - Key first sampled high at edge N -> pulses high in cycle N+1.
  - Scores, combo and multiplier update at edge N+2.
- Accumulator, applied per cycle:
  - base = 2 per perfect_pulse lane, plus 1 per hit-only lane.
  - add = base * multiplier. The multiplier used is the registered value, before this cycle's combo update.
  - The selected player's score += add, saturating at 2^SCORE_W - 1.
- Combo update:
  - If any miss_pulse is set: combo = 0. Miss dominates simultaneous hits, but those hits still score.
  - Otherwise: combo += popcount(hit_pulse), saturating at 2^COMBO_W - 1.
- Multiplier: min(1 + combo / COMBO_STEP, MAX_MULT), registered alongside combo.
- score_clear:
  - Zeroes both scores and combo and sets multiplier = 1 at the next edge.
  - Lane FSMs are unaffected.
  - Pulses arriving in the same cycle are discarded.
- player_sel is sampled in the accumulate cycle, not the key cycle.
- Async reset mid-judgement aborts immediately. No pulse is emitted after reset deasserts until the next valid window entry.

Optional Feature:
GHOST_PENALTY_EN
- Defined: a key edge on a lane in IDLE or JUDGED asserts that lane's miss_pulse (registered, same latency) and clears combo. Scores are unchanged.
- Undefined: edges outside ARMED are ignored.

Decomposition:
- Package score_pkg holds:
  - lane_state_t enum {IDLE, ARMED, JUDGED}
  - the default window constants
  - MULT_W = 3
- Sub-module lane_judge holds one lane's FSM, key_q and registered pulses. It is instantiated NUM_LANES times with a generate loop.
- score_judge holds the adder tree, the combo counter and the saturation logic.

Test Plan:
- Lane 0: ramp y from 400 to 415, key edge at y = 415, player_sel = 1 -> hit_pulse[0] for 1 cycle, no perfect; score_1 = 1 two cycles later; combo = 1.
- Lane 2: key edge at y = 425 -> perfect_pulse[2] and hit_pulse[2]; score increases by 2.
- Lane 1: hold key through 415..435 -> exactly one hit; a second edge at 436 in JUDGED -> no pulse (GHOST_PENALTY_EN undefined).
- Lane 3: y passes 440 while ARMED with no key -> miss_pulse[3]; combo reset from 7 to 0.
- Combo at 7, lanes 0 and 4 hit GOOD in the same cycle, player_sel = 0 -> score_2 += 2 (multiplier 1); combo = 9; multiplier = 2 the next cycle.
- score_1 = 65534, perfect hit at multiplier 4 -> score_1 saturates at 65535. Assert Reset_n = 0 mid-window -> all outputs 0, multiplier = 1.
